// File: rtl/pe_array_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_seq_ctrl
// Description : PE-array sequencer for the HEVC ME datapath: current-block
//               preload, then a per-column DS / FS / skip walk of the window.
// Revision    : 1.0  initial parametrised release
// ============================================================================
module pe_array_seq_ctrl #(
    parameter int SR_COLS    = 32,
    parameter int COL_W      = 5,
    parameter int ROW_W      = 7,
    parameter int PRE_CYCLES = 64,
    parameter int DS_ROWS    = 38,
    parameter int FS_ROWS    = 21,
    parameter int NUM_SUB    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [2*SR_COLS-1:0]   col_mode,
    output logic                   busy,
    output logic                   done,
    output logic                   pass_valid,
    output logic                   in_curr_enable,
    output logic                   cb_select,
    output logic [1:0]             abs_control,
    output logic                   change_ref,
    output logic                   ref_input_control,
    output logic [COL_W-1:0]       search_column_count,
    output logic [ROW_W-1:0]       search_row_count
);

    localparam int c_PRE_W    = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
    localparam int c_MAX_ROWS = (DS_ROWS > FS_ROWS) ? DS_ROWS : FS_ROWS;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PRE  = 3'd1;
    localparam logic [2:0] c_SEL  = 3'd2;
    localparam logic [2:0] c_DS   = 3'd3;
    localparam logic [2:0] c_FS   = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    if (ROW_W < $clog2(c_MAX_ROWS)) begin : g_row_w_err
        $error("ROW_W too narrow for max(DS_ROWS,FS_ROWS)-1");
    end
    if ((1 << COL_W) < SR_COLS) begin : g_col_w_err
        $error("COL_W too narrow for SR_COLS");
    end

    logic [2:0]           r_state;
    logic [2*SR_COLS-1:0] r_mode;
    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [1:0]           r_pass;
    logic [c_PRE_W-1:0]   r_pre;
    logic [1:0]           w_cur_mode;
    logic                 w_last_col;
    logic                 w_abort;

    always_comb begin
        w_cur_mode = 2'b00;
        for (int c = 0; c < SR_COLS; c++) begin
            if (r_col == COL_W'(c)) begin
                w_cur_mode = r_mode[2*c +: 2];
            end
        end
    end

    assign w_last_col = (r_col == COL_W'(SR_COLS - 1));
    assign w_abort    = abort && (r_state != c_IDLE);

    // Sequencing state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_mode  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_pass  <= '0;
            r_pre   <= '0;
        end else if (w_abort) begin
            r_state <= c_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_pass  <= '0;
            r_pre   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_PRE;
                        r_mode  <= col_mode;
                        r_col   <= '0;
                        r_pre   <= '0;
                    end
                end
                c_PRE: begin
                    if (r_pre == c_PRE_W'(PRE_CYCLES - 1)) begin
                        r_pre   <= '0;
                        r_state <= c_SEL;
                    end else begin
                        r_pre <= r_pre + c_PRE_W'(1);
                    end
                end
                c_SEL: begin
                    r_row  <= '0;
                    r_pass <= '0;
                    if (w_cur_mode == 2'd1) begin
                        r_state <= c_DS;
                    end else if (w_cur_mode == 2'd2) begin
                        r_state <= c_FS;
                    end else if (w_last_col) begin
                        r_state <= c_DONE;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                c_DS: begin
                    if (r_row == ROW_W'(DS_ROWS - 1)) begin
                        r_row <= '0;
                        if (r_pass == 2'd0) begin
                            r_pass <= 2'd1;
                        end else begin
                            r_pass <= '0;
                            if (w_last_col) begin
                                r_state <= c_DONE;
                            end else begin
                                r_col   <= r_col + COL_W'(1);
                                r_state <= c_SEL;
                            end
                        end
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                c_FS: begin
                    if (r_row == ROW_W'(FS_ROWS - 1)) begin
                        r_row <= '0;
                        if (r_pass != 2'(NUM_SUB - 1)) begin
                            r_pass <= r_pass + 2'd1;
                        end else begin
                            r_pass <= '0;
                            if (w_last_col) begin
                                r_state <= c_DONE;
                            end else begin
                                r_col   <= r_col + COL_W'(1);
                                r_state <= c_SEL;
                            end
                        end
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Registered decode: outputs reflect the state/counters of the previous cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy                <= 1'b0;
            done                <= 1'b0;
            pass_valid          <= 1'b0;
            in_curr_enable      <= 1'b0;
            cb_select           <= 1'b1;
            abs_control         <= 2'd0;
            change_ref          <= 1'b0;
            ref_input_control   <= 1'b0;
            search_column_count <= '0;
            search_row_count    <= '0;
        end else begin
            done                <= 1'b0;
            pass_valid          <= 1'b0;
            in_curr_enable      <= 1'b0;
            cb_select           <= 1'b1;
            abs_control         <= 2'd0;
            change_ref          <= 1'b0;
            ref_input_control   <= 1'b0;
            search_row_count    <= '0;
            search_column_count <= r_col;
            if (w_abort) begin
                busy                <= 1'b0;
                search_column_count <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            busy                <= 1'b1;
                            search_column_count <= '0;
                        end
                    end
                    c_PRE: begin
                        in_curr_enable <= 1'b1;
                        cb_select      <= (r_pre < c_PRE_W'(PRE_CYCLES / 2));
                    end
                    c_DS: begin
                        pass_valid        <= 1'b1;
                        cb_select         <= ~r_pass[0];
                        ref_input_control <= 1'b1;
                        search_row_count  <= r_row;
                        if (r_row < ROW_W'(8)) begin
                            abs_control <= {r_pass[0], 1'b0};
                            change_ref  <= 1'b1;
                        end else if (r_row < ROW_W'(DS_ROWS - 4)) begin
                            // even rows accumulate the odd SAD, odd rows shift reference
                            abs_control <= {r_pass[0], ~r_row[0]};
                            change_ref  <= r_row[0];
                        end else begin
                            abs_control <= {r_pass[0], 1'b1};
                            change_ref  <= 1'b1;
                        end
                    end
                    c_FS: begin
                        pass_valid        <= 1'b1;
                        cb_select         <= 1'b0;
                        change_ref        <= 1'b1;
                        abs_control       <= r_pass;
                        ref_input_control <= (r_row < ROW_W'(4));
                        search_row_count  <= r_row;
                    end
                    c_DONE: begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_seq_ctrl
// Description : Scoreboard bench for pe_array_seq_ctrl (3-column window).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pe_array_seq_ctrl;

    localparam int c_COLS = 3;
    localparam int c_PRE  = 64;
    localparam int c_DS   = 38;
    localparam int c_FS   = 21;
    localparam int c_SUB  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [2*c_COLS-1:0]   col_mode = '0;
    logic                  busy, done, pass_valid, in_curr_enable, cb_select;
    logic [1:0]            abs_control;
    logic                  change_ref, ref_input_control;
    logic [4:0]            search_column_count;
    logic [6:0]            search_row_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [20:0] exp_q[$];
    logic [20:0] w_obs;

    pe_array_seq_ctrl #(.SR_COLS(c_COLS)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .col_mode            (col_mode),
        .busy                (busy),
        .done                (done),
        .pass_valid          (pass_valid),
        .in_curr_enable      (in_curr_enable),
        .cb_select           (cb_select),
        .abs_control         (abs_control),
        .change_ref          (change_ref),
        .ref_input_control   (ref_input_control),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count)
    );

    always #5 clk = ~clk;

    assign w_obs = {busy, done, pass_valid, in_curr_enable, cb_select, abs_control,
                    change_ref, ref_input_control, search_column_count, search_row_count};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [20:0] mk(input logic b, input logic d, input logic pv,
                                       input logic ice, input logic cb, input logic [1:0] ab,
                                       input logic cr, input logic ric, input int col, input int row);
        return {b, d, pv, ice, cb, ab, cr, ric, 5'(col), 7'(row)};
    endfunction

    // Expected output stream, one entry per clock edge starting with the start edge
    task automatic build_job(input logic [2*c_COLS-1:0] m);
        logic [1:0] md;
        logic       hi, cr;
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < c_PRE; k++)
            exp_q.push_back(mk(1, 0, 0, 1, (k < c_PRE / 2), 0, 0, 0, 0, 0));
        for (int c = 0; c < c_COLS; c++) begin
            md = m[2*c +: 2];
            exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, c, 0));
            if (md == 2'd1) begin
                for (int p = 0; p < 2; p++)
                    for (int r = 0; r < c_DS; r++) begin
                        cr = (r < 8) || (r >= c_DS - 4) || (r % 2 == 1);
                        hi = (r >= c_DS - 4) || ((r >= 8) && (r % 2 == 0));
                        exp_q.push_back(mk(1, 0, 1, 0, (p == 0), {p[0], hi}, cr, 1, c, r));
                    end
            end else if (md == 2'd2) begin
                for (int s = 0; s < c_SUB; s++)
                    for (int r = 0; r < c_FS; r++)
                        exp_q.push_back(mk(1, 0, 1, 0, 0, s[1:0], 1, (r < 4), c, r));
            end
        end
        exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, c_COLS - 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, c_COLS - 1, 0));
    endtask

    task automatic step();
        logic [20:0] v;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check_eq("out", {11'b0, w_obs}, {11'b0, v});
        end
    endtask

    // start_at/abort_at: loop index whose inputs carry the pulse; stop_at bounds the run
    task automatic run_job(input logic [2*c_COLS-1:0] m, input int start_at,
                           input int abort_at, input int stop_at);
        int n;
        build_job(m);
        if (abort_at >= 0) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        end
        col_mode = m;
        start    = 1'b1;
        step();
        start    = 1'b0;
        col_mode = 6'($urandom);
        n = 0;
        while (exp_q.size() > 0 && n < stop_at) begin
            start = (n == start_at);
            abort = (n == abort_at);
            step();
            n++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (n < stop_at) check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", {11'b0, w_obs}, {11'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(6'b00_01_01, 150, -1, 5000);
        run_job(6'b10_00_10, -1, -1, 5000);
        run_job(6'b00_00_00, -1, -1, 5000);
        run_job(6'b01_01_01, -1, 123, 5000);
        run_job(6'b01_01_01, -1, -1, 5000);

        run_job(6'b10_00_10, -1, -1, 100);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {11'b0, w_obs}, {11'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(6'b01_10_01, -1, -1, 5000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
